// File: rtl/uart_rx_deser.sv
// UART receive deserializer: synchronizes rx, frames 8N1 bytes sampled at mid-bit,
// and holds each good byte in a one-entry valid/ready register with sticky error flags.
module uart_rx_deser #(
    parameter int SYNC_STAGES = 2,
    parameter int RATE_W      = 16
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [RATE_W-1:0] rate,
    input  logic              rx,
    output logic [7:0]        data,
    output logic              valid,
    input  logic              ready,
    output logic              frame_err,
    output logic              overrun,
    input  logic              err_clr,
    output logic              rts,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HI
    } state_t;

    state_t            state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [RATE_W-1:0] cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;

    logic              rxs;
    logic [RATE_W-1:0] eff_rate;
    logic [RATE_W-1:0] half_m1;
    logic [RATE_W-1:0] last;
    logic              deliver;
    logic              ferr_set;
    logic              ovr_set;

    assign rxs      = sync_q[SYNC_STAGES-1];
    assign eff_rate = (rate < RATE_W'(4)) ? RATE_W'(4) : rate;
    assign half_m1  = (rate_q >> 1) - RATE_W'(1);
    assign last     = rate_q - RATE_W'(1);

    always_ff @(posedge clk) begin
        if (!nReset) begin
            sync_q  <= '1;
            state_q <= S_IDLE;
            rate_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
            state_q <= state_d;
            rate_q  <= rate_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rate_d   = rate_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        deliver  = 1'b0;
        ferr_set = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = S_START;
                    rate_d  = eff_rate;
                end
            end
            S_START: begin
                if (cnt_q == half_m1) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rxs ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + RATE_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == last) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + RATE_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == last) begin
                    cnt_d = '0;
                    if (rxs) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = S_WAIT_HI;
                    end
                end else begin
                    cnt_d = cnt_q + RATE_W'(1);
                end
            end
            S_WAIT_HI: begin
                cnt_d = '0;
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A consume and a delivery on the same edge refill the register instead of overrunning.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        ovr_set = 1'b0;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (deliver) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end
        if (err_clr) begin
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (ferr_set) begin
            ferr_d = 1'b1;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign rts       = ~valid_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: bit-banged 8N1 frames checked against a frame-level model
// of the holding register and sticky error flags.
module tb_uart_rx_deser;

    logic        clk = 1'b0;
    logic        nReset;
    logic [15:0] rate;
    logic        rx;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic        frame_err;
    logic        overrun;
    logic        err_clr;
    logic        rts;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int e0    = 0;
    int rise_cyc = -1;
    bit pv    = 1'b0;
    bit saw_busy = 1'b0;

    logic [7:0] m_data;
    bit         m_valid;
    bit         m_ferr;
    bit         m_ovr;

    uart_rx_deser #(.SYNC_STAGES(2), .RATE_W(16)) dut (
        .clk(clk), .nReset(nReset), .rate(rate), .rx(rx),
        .data(data), .valid(valid), .ready(ready),
        .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr),
        .rts(rts), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid && !pv) rise_cyc = cyc;
        pv = valid;
        if (busy) saw_busy = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"},  32'(data),      32'(m_data));
        check({tag, ".valid"}, 32'(valid),     32'(m_valid));
        check({tag, ".ferr"},  32'(frame_err), 32'(m_ferr));
        check({tag, ".ovr"},   32'(overrun),   32'(m_ovr));
        check({tag, ".rts"},   32'(rts),       32'(!m_valid));
        check({tag, ".busy"},  32'(busy),      32'(0));
    endtask

    function automatic void model_frame(input logic [7:0] b, input bit stopb);
        if (!stopb) m_ferr = 1'b1;
        else if (!m_valid) begin
            m_data  = b;
            m_valid = 1'b1;
        end else m_ovr = 1'b1;
    endfunction

    function automatic void model_reset();
        m_data = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    endfunction

    // rdy_edge >= 0 pulses ready for exactly that clock edge, counted from the start-bit edge.
    task automatic send(input logic [7:0] b, input bit stopb, input int r, input int rdy_edge,
                        input int extra_low, input bit scramble, input bit hold_low);
        int eff;
        logic [9:0] fr;
        eff = (r < 4) ? 4 : r;
        fr  = {stopb, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < eff; j++) begin
                @(negedge clk);
                if (k == 0 && j == 0) e0 = cyc;
                rx = fr[k];
                if (rdy_edge >= 0) ready = ((k * eff + j) == rdy_edge);
                if (scramble && k == 1 && j == 0) rate = 16'($urandom_range(1, 40));
            end
        end
        for (int i = 0; i < extra_low * eff; i++) begin
            @(negedge clk);
            rx = 1'b0;
        end
        @(negedge clk);
        ready = 1'b0;
        rate  = 16'(r);
        if (!hold_low) begin
            rx = 1'b1;
            repeat (eff + 4) @(negedge clk);
        end
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        m_valid = 1'b0;
        check_all(tag);
    endtask

    task automatic clear_errs(input string tag);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        check_all(tag);
    endtask

    initial begin
        int lat;
        int r;
        logic [7:0] b;
        bit stopb;
        logic [9:0] fr;

        nReset = 1'b0; rx = 1'b1; ready = 1'b0; err_clr = 1'b0; rate = 16'd16;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        nReset = 1'b1;
        repeat (3) @(negedge clk);

        // Directed: good byte, latency, consume
        rise_cyc = -1;
        send(8'hA5, 1'b1, 16, -1, 0, 1'b0, 1'b0);
        model_frame(8'hA5, 1'b1);
        lat = rise_cyc - e0 - 1;
        check("a5.latency_in_window", 32'(lat >= 153 && lat <= 155), 32'(1));
        check_all("a5");
        consume("a5_consumed");

        // Directed: start-bit glitch
        saw_busy = 1'b0;
        repeat (4) begin
            @(negedge clk);
            rx = 1'b0;
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch.busy_seen", 32'(saw_busy), 32'(1));
        check_all("glitch");

        // Directed: framing error with line held low afterwards
        send(8'h3C, 1'b0, 16, -1, 2, 1'b0, 1'b1);
        check("ferr.frame_err", 32'(frame_err), 32'(1));
        check("ferr.valid", 32'(valid), 32'(0));
        check("ferr.busy_wait_hi", 32'(busy), 32'(1));
        rx = 1'b1;
        repeat (8) @(negedge clk);
        model_frame(8'h3C, 1'b0);
        check_all("ferr_released");
        clear_errs("ferr_cleared");

        // Directed: overrun, then simultaneous consume+deliver
        rate = 16'd8;
        send(8'h11, 1'b1, 8, -1, 0, 1'b0, 1'b0);
        model_frame(8'h11, 1'b1);
        send(8'h22, 1'b1, 8, -1, 0, 1'b0, 1'b0);
        model_frame(8'h22, 1'b1);
        check_all("overrun");
        consume("overrun_consumed");
        clear_errs("overrun_cleared");
        send(8'h11, 1'b1, 8, -1, 0, 1'b0, 1'b0);
        model_frame(8'h11, 1'b1);
        send(8'h22, 1'b1, 8, 2 + 4 + 9 * 8, 0, 1'b0, 1'b0);
        m_data = 8'h22; m_valid = 1'b1;
        check_all("same_edge");
        consume("same_edge_consumed");

        // Directed: clamped rate, then reset mid-frame
        rate = 16'd2;
        send(8'h5A, 1'b1, 2, -1, 0, 1'b0, 1'b0);
        model_frame(8'h5A, 1'b1);
        check_all("clamp");
        consume("clamp_consumed");
        fr = {1'b1, 8'hC3, 1'b0};
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                rx = fr[k];
            end
        end
        nReset = 1'b0;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        check_all("mid_reset");
        nReset = 1'b1;
        repeat (60) @(negedge clk);
        check_all("post_reset");

        // Randomized frames
        for (int it = 0; it < 40; it++) begin
            r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 24));
            b = 8'($urandom);
            stopb = ($urandom_range(0, 5) != 0);
            rate = 16'(r);
            send(b, stopb, r, -1, 0, 1'($urandom_range(0, 1)), 1'b0);
            model_frame(b, stopb);
            check_all("rand");
            if ($urandom_range(0, 1) == 1) consume("rand_consume");
            if ($urandom_range(0, 3) == 0) clear_errs("rand_clear");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
